// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path:
//   - tx_state_e   : transmitter FSM state encoding (IDLE/START/DATA/STOP)
//   - DATA_BITS    : data bits per frame (8N1)
//   - STOP_BITS    : stop bits per frame (8N1)
//   - FRAME_BITS   : total bit periods per frame (start + data + stop)
//   - calc_divisor : clocks per bit period from clock frequency and baud rate
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

  // sysclk_100k is the clock frequency in units of 100 kHz; the result is
  // truncated, so the actual baud rate is slightly above the requested one.
  function automatic int calc_divisor(input int sysclk_100k, input int baud_rate);
    return (sysclk_100k * 100000) / baud_rate;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// -----------------------------------------------------------------------------
// uart_fifo
// Single-clock synchronous FIFO holding 2**depth_log2 entries.
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset; empties the FIFO
//   push   in   write strobe; accepted only when full=0
//   din    in   write data
//   pop    in   read strobe; honoured only when empty=0
//   dout   out  head entry (valid while empty=0), read combinationally
//   full   out  registered, high when count == depth
//   empty  out  registered, high when count == 0
//   count  out  registered occupancy, depth_log2+1 bits
//
// A push while full is dropped even if a pop happens in the same cycle, so
// full is a plain registered flag with no same-cycle pop bypass.
// -----------------------------------------------------------------------------
module uart_fifo #(
  parameter int depth_log2 = 4,
  parameter int width      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [width-1:0]      din,
  input  logic                  pop,
  output logic [width-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [depth_log2:0]   count
);

  localparam int DEPTH = 1 << depth_log2;
  localparam logic [depth_log2:0] FULL_COUNT = {1'b1, {depth_log2{1'b0}}};

  logic [width-1:0]      mem_q [DEPTH];
  logic [depth_log2-1:0] wr_ptr_q, wr_ptr_d;
  logic [depth_log2-1:0] rd_ptr_q, rd_ptr_d;
  logic [depth_log2:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  do_push;
  logic                  do_pop;

  always_comb begin
    do_push  = push & ~full_q;
    do_pop   = pop & ~empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{(depth_log2-1){1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{(depth_log2-1){1'b0}}, 1'b1};
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + {{depth_log2{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{depth_log2{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
    // Flags follow the post-update occupancy so they are valid the cycle
    // after the push/pop that changed it.
    full_d  = (count_d == FULL_COUNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage carries no reset; pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Buffered 8N1 UART transmitter: bytes written via req/d are queued in a
// FIFO and shifted out LSB first on txd.
//
// Parameters:
//   sysclk_frequency  clk frequency in units of 100 kHz
//   baud              serial bit rate in bits/s
//   fifo_depth_log2   FIFO depth = 2**fifo_depth_log2 bytes
//
// Ports:
//   clk       in   system clock (single domain)
//   reset     in   synchronous active-high reset; aborts any frame
//   d         in   byte to enqueue
//   req       in   single-cycle write strobe for d
//   full      out  FIFO holds fifo_depth bytes (registered)
//   empty     out  FIFO holds 0 bytes (registered)
//   busy      out  FIFO non-empty or frame in progress (registered)
//   overflow  out  sticky; set when a write is dropped because full=1
//   txd       out  serial line, idle high (registered)
//
// Write handshake: req is a one-cycle strobe with no back-pressure; a byte
// is stored when req=1 and full=0 at a clock edge, otherwise it is dropped
// and overflow latches high until reset. req is ignored while reset=1.
//
// Timing: txd is registered from the current FSM state, so the line lags
// the state by one clock. The FSM pops in IDLE one clock after empty falls,
// giving txd=0 two edges after the write edge.
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int sysclk_frequency = 1250,
  parameter int baud             = 115200,
  parameter int fifo_depth_log2  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d,
  input  logic       req,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       txd
);

  localparam int DIVISOR = calc_divisor(sysclk_frequency, baud);
  localparam int CNT_W   = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(DIVISOR - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  logic [7:0]               fifo_dout;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [fifo_depth_log2:0] fifo_count;
  logic                     pop;
  logic                     accept;
  logic                     queue_nonempty_next;

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;
  logic             overflow_q, overflow_d;
  logic             bit_done;

  uart_fifo #(
    .depth_log2 (fifo_depth_log2),
    .width      (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (req),
    .din   (d),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    bit_done   = (baud_cnt_q == '0);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = fifo_dout;
          baud_cnt_d = RELOAD;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          baud_cnt_d = RELOAD;
          bit_cnt_d  = 3'd0;
          state_d    = ST_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          baud_cnt_d = RELOAD;
          // Terminate on an explicit compare with the last index, not on
          // the 3-bit counter wrapping back to zero.
          if (bit_cnt_q == LAST_BIT) begin
            state_d = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_cnt_d = baud_cnt_q - CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          state_d = ST_IDLE;
        end else begin
          baud_cnt_d = baud_cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_q)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_q[0];
      default:  txd_d = 1'b1;
    endcase

    // Post-update FIFO occupancy, mirrored here so busy lands in the same
    // cycle as the FIFO's own registered flags.
    accept              = req & ~fifo_full;
    queue_nonempty_next = accept ||
                          (fifo_count > {{fifo_depth_log2{1'b0}}, pop});

    // state_q keeps busy high through the final STOP cycle, whose txd is
    // still being driven out one clock later.
    busy_d = queue_nonempty_next || (state_d != ST_IDLE) || (state_q != ST_IDLE);

    overflow_d = overflow_q | (req & fifo_full);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign full     = fifo_full;
  assign empty    = fifo_empty;
  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign txd      = txd_q;

endmodule
